stream_config_ctrl: RTL

STREAM_CONFIG_CTRL -- requirements
Module: stream_config_ctrl

---
 rtl/stream_config_ctrl_if.sv | 67 ++++++
 rtl/stream_config_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/stream_config_ctrl_if.sv
// Shared types plus the config write bus and the select/data_type stream bundle.
// config_i: addr/data/valid; stream_config_i: two ready/valid channels (select, data_type).
package stream_config_pkg;
  localparam int CFG_AW = 8;
  localparam int CFG_DW = 32;

  typedef logic [3:0] type_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;
endpackage

interface config_i;
  import stream_config_pkg::*;

  logic [CFG_AW-1:0] addr;
  logic [CFG_DW-1:0] data;
  logic              valid;

  modport s (
    input addr,
    input data,
    input valid
  );

  modport m (
    output addr,
    output data,
    output valid
  );
endinterface

interface stream_config_i #(
  parameter int NUM_SELECT = 4
);
  import stream_config_pkg::*;

  localparam int SEL_W = $clog2(NUM_SELECT);

  logic [SEL_W-1:0] select_data;
  logic             select_valid;
  logic             select_ready;
  type_t            data_type_data;
  logic             data_type_valid;
  logic             data_type_ready;

  modport m (
    output select_data,
    output select_valid,
    input  select_ready,
    output data_type_data,
    output data_type_valid,
    input  data_type_ready
  );

  modport s (
    input  select_data,
    input  select_valid,
    output select_ready,
    input  data_type_data,
    input  data_type_valid,
    output data_type_ready
  );
endinterface

// File: rtl/stream_config_ctrl.sv
// Config-write to stream bridge: two 2-deep FIFOs (select, data_type) with drop/range counters.
// Ports: clk, rst (sync, high), cfg (config_i.s), out (stream_config_i.m),
//   drop_cnt, range_err_cnt (saturating 8-bit), busy (registered, any FIFO non-empty).
// Optional: define STREAM_CONFIG_CTRL_RANGE_CHECK_EN to reject select writes >= NUM_SELECT.
module stream_config_fifo
  import stream_config_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         drop,
  output logic         busy_nxt
);

  occ_t         occ_q;
  occ_t         occ_d;
  logic [W-1:0] mem_q [2];
  logic         rd_q;
  logic         wr_q;
  logic         pop;
  logic         acc;

  // A full FIFO still accepts when the head leaves in the same cycle.
  always_comb begin
    pop      = valid && ready;
    acc      = push && ((occ_q != FULL) || pop);
    drop     = push && !acc;
    occ_d    = occ_q;
    unique case (1'b1)
      acc && !pop: occ_d = occ_t'(occ_q + 2'd1);
      pop && !acc: occ_d = occ_t'(occ_q - 2'd1);
      default:     occ_d = occ_q;
    endcase
    busy_nxt = (occ_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q    <= EMPTY;
      valid    <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      occ_q <= occ_d;
      valid <= busy_nxt;
      if (acc) begin
        mem_q[wr_q] <= din;
        wr_q        <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
    end
  end

  assign dout = mem_q[rd_q];

endmodule

module stream_config_ctrl
  import stream_config_pkg::*;
#(
  parameter int NUM_SELECT  = 4,
  parameter int SELECT_ADDR = 0,
  parameter int TYPE_ADDR   = 1
) (
  input  logic        clk,
  input  logic        rst,
  config_i.s          cfg,
  stream_config_i.m   out,
  output logic [7:0]  drop_cnt,
  output logic [7:0]  range_err_cnt,
  output logic        busy
);

  localparam int SEL_W  = $clog2(NUM_SELECT);
  localparam int TYPE_W = $bits(type_t);

  logic             sel_hit;
  logic             type_hit;
  logic             sel_ok;
  logic             sel_push;
  logic             sel_valid;
  logic [SEL_W-1:0] sel_data;
  logic             sel_drop;
  logic             sel_busy;
  logic             type_valid;
  type_t            type_data;
  logic             type_drop;
  logic             type_busy;
  logic             drop;
  logic             unused_cfg;

  assign sel_hit  = cfg.valid &&
                    (cfg.addr == CFG_AW'(SELECT_ADDR));
  assign type_hit = cfg.valid &&
                    (cfg.addr == CFG_AW'(TYPE_ADDR));

`ifdef STREAM_CONFIG_CTRL_RANGE_CHECK_EN
  logic range_err;

  // Full-width compare: high garbage bits must not alias into range.
  assign sel_ok    = (cfg.data < CFG_DW'(NUM_SELECT));
  assign range_err = sel_hit && !sel_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      range_err_cnt <= '0;
    end else if (range_err && (range_err_cnt != 8'hFF)) begin
      range_err_cnt <= range_err_cnt + 8'd1;
    end
  end
`else
  assign sel_ok        = 1'b1;
  assign range_err_cnt = '0;
`endif

  assign sel_push   = sel_hit && sel_ok;
  assign unused_cfg = ^cfg.data;

  stream_config_fifo #(
    .W (SEL_W)
  ) u_sel_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (sel_push),
    .din      (cfg.data[SEL_W-1:0]),
    .ready    (out.select_ready),
    .valid    (sel_valid),
    .dout     (sel_data),
    .drop     (sel_drop),
    .busy_nxt (sel_busy)
  );

  stream_config_fifo #(
    .W (TYPE_W)
  ) u_type_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (type_hit),
    .din      (cfg.data[TYPE_W-1:0]),
    .ready    (out.data_type_ready),
    .valid    (type_valid),
    .dout     (type_data),
    .drop     (type_drop),
    .busy_nxt (type_busy)
  );

  assign out.select_valid    = sel_valid;
  assign out.select_data     = sel_data;
  assign out.data_type_valid = type_valid;
  assign out.data_type_data  = type_data;

  // Only one address per cycle, so at most one channel drops at a time.
  assign drop = sel_drop || type_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      busy <= sel_busy || type_busy;
      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule
